// File: rtl/flit_injector.sv
// flit_injector: turns a packet request plus payload stream into HEADER/BODY/TAIL
// flits for a router input FIFO. Define INJ_STATS_EN for pkt_sent/flit_sent counters.
module flit_injector #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int LEN_W  = 4,
   parameter int SRC_ID = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pkt_valid,
   output logic              pkt_ready,
   input  logic [ADDR_W-1:0] pkt_dest,
   input  logic [LEN_W-1:0]  pkt_len,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic              ready_in,
   output logic              wr_en,
   output logic [DATA_W-1:0] flit_out,
   output logic [2:0]        flit_id_out
`ifdef INJ_STATS_EN
   ,
   output logic [15:0]       pkt_sent,
   output logic [15:0]       flit_sent
`endif
);

   typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL0} state_e;

   localparam logic [2:0] ID_HDR  = 3'b001;
   localparam logic [2:0] ID_BODY = 3'b010;
   localparam logic [2:0] ID_TAIL = 3'b100;
   localparam logic [ADDR_W-1:0] SRC = ADDR_W'(SRC_ID);

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic              wr_en_q, wr_en_d;
   logic [DATA_W-1:0] flit_q, flit_d;
   logic [2:0]        id_q, id_d;
   logic              body_fire;
`ifdef INJ_STATS_EN
   logic [15:0]       pkt_sent_q, pkt_sent_d;
   logic [15:0]       flit_sent_q, flit_sent_d;
`endif

   // State, request and output flit registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         dest_q      <= '0;
         wr_en_q     <= 1'b0;
         flit_q      <= '0;
         id_q        <= 3'b000;
`ifdef INJ_STATS_EN
         pkt_sent_q  <= '0;
         flit_sent_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         dest_q      <= dest_d;
         wr_en_q     <= wr_en_d;
         flit_q      <= flit_d;
         id_q        <= id_d;
`ifdef INJ_STATS_EN
         pkt_sent_q  <= pkt_sent_d;
         flit_sent_q <= flit_sent_d;
`endif
      end
   end

   // Next state: advance only when the FIFO takes the current flit
   always_comb begin
      state_d   = state_q;
      body_fire = (state_q == BODY) && data_valid && ready_in;
      unique case (state_q)
         IDLE:  if (pkt_valid) state_d = HEAD;
         HEAD:  if (ready_in)
                   state_d = (remaining_q != '0) ? BODY : TAIL0;
         BODY:  if (body_fire && remaining_q == LEN_W'(1))
                   state_d = IDLE;
         TAIL0: if (ready_in) state_d = IDLE;
      endcase
   end

   // Datapath: latch the request and build the next flit
   always_comb begin
      remaining_d = remaining_q;
      dest_d      = dest_q;
      wr_en_d     = 1'b0;
      flit_d      = flit_q;
      id_d        = id_q;
      unique case (state_q)
         IDLE: if (pkt_valid) begin
            dest_d      = pkt_dest;
            remaining_d = pkt_len;
         end
         HEAD: if (ready_in) begin
            wr_en_d = 1'b1;
            flit_d  = DATA_W'({SRC, dest_q, remaining_q});
            id_d    = ID_HDR;
         end
         BODY: if (body_fire) begin
            wr_en_d     = 1'b1;
            flit_d      = data_in;
            id_d        = (remaining_q == LEN_W'(1)) ? ID_TAIL : ID_BODY;
            remaining_d = remaining_q - LEN_W'(1);
         end
         TAIL0: if (ready_in) begin
            wr_en_d = 1'b1;
            flit_d  = '0;
            id_d    = ID_TAIL;
         end
      endcase
`ifdef INJ_STATS_EN
      pkt_sent_d  = pkt_sent_q + 16'(wr_en_d && id_d == ID_TAIL);
      flit_sent_d = flit_sent_q + 16'(wr_en_d);
`endif
   end

   // Handshake outputs and registered FIFO write port
   always_comb begin
      pkt_ready   = (state_q == IDLE);
      data_ready  = (state_q == BODY) && ready_in;
      wr_en       = wr_en_q;
      flit_out    = flit_q;
      flit_id_out = id_q;
`ifdef INJ_STATS_EN
      pkt_sent    = pkt_sent_q;
      flit_sent   = flit_sent_q;
`endif
   end

endmodule

// File: tb/tb_flit_injector.sv
// tb_flit_injector: random and directed packets checked against a
// flit-list model of the packet format.
module tb_flit_injector;

   localparam int SRC = 2;

   typedef logic [34:0] flit_t;
   typedef flit_t fq_t[$];

   logic        clk;
   logic        rst;
   logic        pkt_valid;
   logic        pkt_ready;
   logic [3:0]  pkt_dest;
   logic [3:0]  pkt_len;
   logic [31:0] data_in;
   logic        data_valid;
   logic        data_ready;
   logic        ready_in;
   logic        wr_en;
   logic [31:0] flit_out;
   logic [2:0]  flit_id_out;
`ifdef INJ_STATS_EN
   logic [15:0] pkt_sent;
   logic [15:0] flit_sent;
`endif

   int checks = 0;
   int failures = 0;
   int exp_pkts = 0;
   int exp_flits = 0;

   flit_t obs_q[$];
   int    obs_cyc[$];
   bit    obs_rdy[$];
   int    cyc = 0;
   bit    cap_rdy;

   flit_injector #(
      .DATA_W(32), .ADDR_W(4), .LEN_W(4), .SRC_ID(SRC)
   ) dut (
      .clk(clk), .rst(rst),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
      .pkt_dest(pkt_dest), .pkt_len(pkt_len),
      .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready), .ready_in(ready_in),
      .wr_en(wr_en), .flit_out(flit_out),
      .flit_id_out(flit_id_out)
`ifdef INJ_STATS_EN
      , .pkt_sent(pkt_sent), .flit_sent(flit_sent)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every flit written, its cycle, and ready_in at the loading edge
   always @(posedge clk) begin
      cap_rdy = ready_in;
      cyc = cyc + 1;
      #1;
      if (wr_en === 1'b1) begin
         obs_q.push_back({flit_id_out, flit_out});
         obs_cyc.push_back(cyc);
         obs_rdy.push_back(cap_rdy);
      end
   end

   // Expected flit list of one packet
   function automatic fq_t model(input int dest, input int len,
                                 input logic [31:0] pay[$]);
      fq_t q;
      q.push_back({3'b001, 32'((SRC << 8) | (dest << 4) | len)});
      if (len == 0) q.push_back({3'b100, 32'h0});
      for (int j = 0; j < len; j++)
         q.push_back({(j == len - 1) ? 3'b100 : 3'b010, pay[j]});
      return q;
   endfunction

   // Drive one packet; optional 3-cycle forced stall after hold_at flits
   task automatic drive_pkt(input logic [3:0] dest, input logic [3:0] len,
                            input logic [31:0] pay[$], input int stall_pct,
                            input int gap_pct, input int hold_at,
                            output int tmo, output int dr_any,
                            output int dr_bad);
      int n0, i, hold, need;
      bit req, held;
      n0 = obs_q.size();
      need = (len == 0) ? 2 : int'(len) + 1;
      i = 0; hold = 0; req = 0; held = 0;
      tmo = 1; dr_any = 0; dr_bad = 0;
      for (int b = 0; b < 600; b++) begin
         @(negedge clk);
         if (obs_q.size() >= n0 + need) begin
            tmo = 0;
            break;
         end
         if (!held && hold_at >= 0 && obs_q.size() - n0 == hold_at) begin
            held = 1;
            hold = 3;
         end
         pkt_valid = !req;
         pkt_dest = dest;
         pkt_len = len;
         if (hold > 0) begin
            ready_in = 1'b0;
            hold--;
         end else begin
            ready_in = int'($urandom_range(99)) >= stall_pct;
         end
         data_valid = (i < int'(len)) &&
                      (int'($urandom_range(99)) >= gap_pct);
         data_in = (i < int'(len)) ? pay[i] : $urandom();
         #1;
         if (data_ready) dr_any++;
         if (data_ready && !ready_in) dr_bad++;
         if (pkt_valid && pkt_ready) req = 1;
         if (data_valid && data_ready) i++;
      end
      pkt_valid = 1'b0;
      data_valid = 1'b0;
      ready_in = 1'b1;
      exp_pkts++;
      exp_flits += need;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      pkt_valid = 0; pkt_dest = 0; pkt_len = 0;
      data_in = 0; data_valid = 0; ready_in = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_wr_en got %b want 0", wr_en);
      end
      checks++;
      if (flit_id_out !== 3'b000) begin
         failures++;
         $display("FAIL reset_id got %b want 000", flit_id_out);
      end
      checks++;
      if (flit_out !== 32'h0) begin
         failures++;
         $display("FAIL reset_flit got %h want 0", flit_out);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (pkt_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_pkt_ready got %b want 1", pkt_ready);
      end
   endtask

   task automatic test_basic();
      logic [31:0] pay[$];
      fq_t e;
      int n0, tmo, dra, drb;
      pay = '{32'hA, 32'hB, 32'hC};
      e = model(5, 3, pay);
      n0 = obs_q.size();
      drive_pkt(4'd5, 4'd3, pay, 0, 0, -1, tmo, dra, drb);
      repeat (3) @(negedge clk);
      checks++;
      if (tmo != 0 || obs_q.size() - n0 != 4) begin
         failures++;
         $display("FAIL basic_count got %0d want 4", obs_q.size() - n0);
      end
      for (int k = 0; k < 4 && n0 + k < obs_q.size(); k++) begin
         checks++;
         if (obs_q[n0+k] !== e[k]) begin
            failures++;
            $display("FAIL basic_flit%0d got %h want %h", k, obs_q[n0+k], e[k]);
         end
      end
      for (int k = 0; k < 3 && n0 + k + 1 < obs_q.size(); k++) begin
         checks++;
         if (obs_cyc[n0+k+1] - obs_cyc[n0+k] != 1) begin
            failures++;
            $display("FAIL basic_gap%0d got %0d want 1", k,
                     obs_cyc[n0+k+1] - obs_cyc[n0+k]);
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] pay[$];
      fq_t e;
      int n0, tmo, dra, drb;
      pay = '{32'hA, 32'hB, 32'hC};
      e = model(5, 3, pay);
      n0 = obs_q.size();
      drive_pkt(4'd5, 4'd3, pay, 0, 0, 2, tmo, dra, drb);
      repeat (3) @(negedge clk);
      checks++;
      if (tmo != 0 || obs_q.size() - n0 != 4) begin
         failures++;
         $display("FAIL stall_count got %0d want 4", obs_q.size() - n0);
      end
      for (int k = 0; k < 4 && n0 + k < obs_q.size(); k++) begin
         checks++;
         if (obs_q[n0+k] !== e[k]) begin
            failures++;
            $display("FAIL stall_flit%0d got %h want %h", k, obs_q[n0+k], e[k]);
         end
      end
      if (obs_q.size() - n0 >= 3) begin
         checks++;
         if (obs_cyc[n0+2] - obs_cyc[n0+1] != 4) begin
            failures++;
            $display("FAIL stall_gap got %0d want 4",
                     obs_cyc[n0+2] - obs_cyc[n0+1]);
         end
      end
      checks++;
      if (drb != 0) begin
         failures++;
         $display("FAIL stall_data_ready got %0d want 0", drb);
      end
   endtask

   task automatic test_zero_len();
      logic [31:0] pay[$];
      fq_t e;
      int n0, tmo, dra, drb;
      pay = {};
      e = model(7, 0, pay);
      n0 = obs_q.size();
      drive_pkt(4'd7, 4'd0, pay, 30, 0, -1, tmo, dra, drb);
      repeat (3) @(negedge clk);
      checks++;
      if (tmo != 0 || obs_q.size() - n0 != 2) begin
         failures++;
         $display("FAIL zero_count got %0d want 2", obs_q.size() - n0);
      end
      for (int k = 0; k < 2 && n0 + k < obs_q.size(); k++) begin
         checks++;
         if (obs_q[n0+k] !== e[k]) begin
            failures++;
            $display("FAIL zero_flit%0d got %h want %h", k, obs_q[n0+k], e[k]);
         end
      end
      checks++;
      if (dra != 0) begin
         failures++;
         $display("FAIL zero_data_ready got %0d want 0", dra);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] p1[$];
      logic [31:0] p2[$];
      fq_t e;
      fq_t e2;
      int n0, idx;
      p1 = '{32'h11};
      p2 = '{32'h22};
      e = model(1, 1, p1);
      e2 = model(1, 1, p2);
      foreach (e2[k]) e.push_back(e2[k]);
      n0 = obs_q.size();
      idx = 0;
      for (int b = 0; b < 40; b++) begin
         @(negedge clk);
         if (obs_q.size() >= n0 + 4) break;
         pkt_valid = 1'b1; pkt_dest = 4'd1; pkt_len = 4'd1;
         ready_in = 1'b1; data_valid = 1'b1;
         data_in = (idx == 0) ? 32'h11 : 32'h22;
         #1;
         if (data_valid && data_ready) idx++;
      end
      pkt_valid = 1'b0;
      data_valid = 1'b0;
      exp_pkts += 2;
      exp_flits += 4;
      repeat (4) @(negedge clk);
      checks++;
      if (obs_q.size() - n0 != 4) begin
         failures++;
         $display("FAIL b2b_count got %0d want 4", obs_q.size() - n0);
      end
      for (int k = 0; k < 4 && n0 + k < obs_q.size(); k++) begin
         checks++;
         if (obs_q[n0+k] !== e[k]) begin
            failures++;
            $display("FAIL b2b_flit%0d got %h want %h", k, obs_q[n0+k], e[k]);
         end
      end
      if (obs_q.size() - n0 >= 3) begin
         checks++;
         if (obs_cyc[n0+2] - obs_cyc[n0+1] != 2) begin
            failures++;
            $display("FAIL b2b_idle_gap got %0d want 2",
                     obs_cyc[n0+2] - obs_cyc[n0+1]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] pay[$];
      fq_t e;
      int n1, tmo, dra, drb;
      @(negedge clk);
      pkt_valid = 1'b1; pkt_dest = 4'd3; pkt_len = 4'd5;
      ready_in = 1'b1; data_valid = 1'b1; data_in = 32'h5555_0001;
      @(negedge clk);
      pkt_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (wr_en !== 1'b1) begin
         failures++;
         $display("FAIL arst_pre_wr_en got %b want 1", wr_en);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (wr_en !== 1'b0 || flit_id_out !== 3'b000 || flit_out !== 32'h0) begin
         failures++;
         $display("FAIL arst_outputs got %b/%b/%h want 0/000/0",
                  wr_en, flit_id_out, flit_out);
      end
`ifdef INJ_STATS_EN
      checks++;
      if (pkt_sent !== 16'h0 || flit_sent !== 16'h0) begin
         failures++;
         $display("FAIL arst_stats got %0d/%0d want 0/0", pkt_sent, flit_sent);
      end
`endif
      exp_pkts = 0;
      exp_flits = 0;
      @(negedge clk);
      rst = 1'b1;
      data_valid = 1'b0;
      #1;
      checks++;
      if (pkt_ready !== 1'b1) begin
         failures++;
         $display("FAIL arst_pkt_ready got %b want 1", pkt_ready);
      end
      pay = '{32'hDEAD_BEEF};
      e = model(9, 1, pay);
      n1 = obs_q.size();
      drive_pkt(4'd9, 4'd1, pay, 0, 0, -1, tmo, dra, drb);
      repeat (3) @(negedge clk);
      checks++;
      if (tmo != 0 || obs_q.size() - n1 != 2) begin
         failures++;
         $display("FAIL arst_next_count got %0d want 2", obs_q.size() - n1);
      end
      for (int k = 0; k < 2 && n1 + k < obs_q.size(); k++) begin
         checks++;
         if (obs_q[n1+k] !== e[k]) begin
            failures++;
            $display("FAIL arst_next_flit%0d got %h want %h", k, obs_q[n1+k], e[k]);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] pay[$];
      fq_t e;
      int n0, tmo, dra, drb, len, dest, bad_rdy, bad_dr, to_cnt;
      n0 = obs_q.size();
      e = {};
      bad_dr = 0;
      to_cnt = 0;
      for (int p = 0; p < 16; p++) begin
         len = (p == 0) ? 15 : (p == 1) ? 0 : int'($urandom_range(15));
         dest = int'($urandom_range(15));
         pay = {};
         for (int j = 0; j < len; j++) pay.push_back($urandom());
         begin
            fq_t m;
            m = model(dest, len, pay);
            foreach (m[k]) e.push_back(m[k]);
         end
         drive_pkt(4'(dest), 4'(len), pay, 30, 30, -1, tmo, dra, drb);
         to_cnt += tmo;
         bad_dr += drb;
         if (len == 0) bad_dr += dra;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (to_cnt != 0 || obs_q.size() - n0 != e.size()) begin
         failures++;
         $display("FAIL rand_count got %0d want %0d timeouts %0d",
                  obs_q.size() - n0, e.size(), to_cnt);
      end
      for (int k = 0; k < e.size() && n0 + k < obs_q.size(); k++) begin
         checks++;
         if (obs_q[n0+k] !== e[k]) begin
            failures++;
            $display("FAIL rand_flit%0d got %h want %h", k, obs_q[n0+k], e[k]);
         end
      end
      bad_rdy = 0;
      for (int k = n0; k < obs_q.size(); k++)
         if (!obs_rdy[k]) bad_rdy++;
      checks++;
      if (bad_rdy != 0) begin
         failures++;
         $display("FAIL rand_wr_no_ready got %0d want 0", bad_rdy);
      end
      checks++;
      if (bad_dr != 0) begin
         failures++;
         $display("FAIL rand_data_ready got %0d want 0", bad_dr);
      end
`ifdef INJ_STATS_EN
      checks++;
      if (pkt_sent !== 16'(exp_pkts) || flit_sent !== 16'(exp_flits)) begin
         failures++;
         $display("FAIL rand_stats got %0d/%0d want %0d/%0d",
                  pkt_sent, flit_sent, exp_pkts, exp_flits);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero_len();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
